// File: rtl/mult_pkg.sv
// mult_pkg: shared width defaults, counter sizing and FSM state encoding for the multiplier
package mult_pkg;
  localparam int WIDTH_DEF = 32;
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction
  localparam int CNT_W = cnt_width(WIDTH_DEF);
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;
endpackage

// File: rtl/mult_step.sv
// mult_step: one shift-add step of an unsigned sequential multiplier
module mult_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   mcand,
  output logic [2*WIDTH-1:0] nxt
);
  logic [WIDTH:0] sum;
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
  assign nxt = {sum, acc[WIDTH-1:1]};
endmodule

// File: rtl/mult_sequencer.sv
// mult_sequencer: valid/ready unsigned multiplier, one shift-add step per cycle
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               busy
);
  localparam int CW = cnt_width(WIDTH);
  state_t             state;
  logic [2*WIDTH-1:0] acc, nxt;
  logic [WIDTH-1:0]   mreg;
  logic [CW-1:0]      cnt;
  mult_step #(.WIDTH(WIDTH)) u_step (.acc(acc), .mcand(mreg), .nxt(nxt));
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      mreg  <= '0;
      cnt   <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else if (state == IDLE && in_valid) begin
      mreg  <= in2;
      acc   <= {{WIDTH{1'b0}}, in1};
      cnt   <= '0;
      state <= RUN;
    end else if (state == RUN) begin
      acc <= nxt;
      cnt <= cnt + CW'(1);
      if (cnt == CW'(WIDTH - 1)) state <= DONE;
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
    end
  end
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = !in_ready;
  assign out       = out_valid ? acc : '0;
endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: directed and random checks against an edge-counting product model
module tb_mult_sequencer;
  localparam int W = 32;
  logic           clock = 0;
  logic           reset, in_valid, flush, out_ready;
  logic [W-1:0]   in1, in2;
  logic           in_ready, out_valid, busy;
  logic [2*W-1:0] out;
  int n_checks = 0;
  int n_fail   = 0;

  mult_sequencer #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an operation is simply "accepted at edge A with product P"; the result
  // is offered from edge A+W until consumed, flushed or reset.
  int             cyc = 0;
  int             m_acc = 0;
  bit             m_act = 0;
  bit             started = 0;
  logic [2*W-1:0] m_prod = '0;
  always @(posedge clock) begin
    bit done_b;
    cyc++;
    done_b = m_act && (cyc - 1 - m_acc >= W);
    if (reset) m_act = 0;
    else if (flush) m_act = 0;
    else if (!m_act) begin
      if (in_valid) begin
        m_act  = 1;
        m_acc  = cyc;
        m_prod = 64'(in1) * 64'(in2);
      end
    end else if (done_b && out_ready) m_act = 0;
    started = 1;
  end

  always @(negedge clock) begin
    if (started) begin
      bit ev;
      ev = m_act && (cyc - m_acc >= W);
      check("in_ready", 64'(in_ready), 64'(!m_act));
      check("busy", 64'(busy), 64'(m_act));
      check("out_valid", 64'(out_valid), 64'(ev));
      check("out", out, ev ? m_prod : 64'd0);
    end
  end

  task automatic cyc_n(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    in1 = a; in2 = b; in_valid = 1;
    cyc_n(1);
    in_valid = 0; in1 = '0; in2 = '0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      cyc_n(1);
      lat++;
    end
  endtask

  task automatic directed(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [63:0] exp);
    int lat;
    start_op(a, b);
    wait_valid(lat);
    check({nm, "_latency"}, 64'(lat), 64'd32);
    check({nm, "_out"}, out, exp);
    out_ready = 1;
    cyc_n(1);
    out_ready = 0;
    check({nm, "_idle"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int lat, seen;
    reset = 1; in_valid = 0; flush = 0; out_ready = 0; in1 = '0; in2 = '0;
    cyc_n(2);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out", out, 64'd0);
    reset = 0;
    cyc_n(1);
    directed("basic", 32'd3, 32'd5, 64'd15);
    directed("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    directed("zero", 32'd0, 32'hFFFF_FFFF, 64'd0);
    directed("hold", 32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080);
    // backpressure with a competing request
    start_op(32'd9, 32'd11);
    wait_valid(lat);
    in_valid = 1; in1 = 32'd2; in2 = 32'd2;
    cyc_n(5);
    check("bp_out", out, 64'd99);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_valid", 64'(out_valid), 64'd1);
    in_valid = 0; out_ready = 1;
    cyc_n(1);
    out_ready = 0;
    check("bp_idle", 64'(in_ready), 64'd1);
    // reset mid-run
    start_op(32'd9, 32'd9);
    cyc_n(10);
    reset = 1;
    cyc_n(1);
    reset = 0;
    check("rst_mid_idle", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (40) begin
      cyc_n(1);
      if (out_valid) seen++;
    end
    check("rst_mid_no_valid", 64'(seen), 64'd0);
    directed("after_rst", 32'd7, 32'd6, 64'd42);
    // flush in RUN
    start_op(32'd100, 32'd3);
    cyc_n(5);
    flush = 1;
    cyc_n(1);
    flush = 0;
    check("flush_run_idle", 64'(in_ready), 64'd1);
    check("flush_run_out", out, 64'd0);
    // flush in DONE
    start_op(32'd100, 32'd3);
    wait_valid(lat);
    check("flush_done_pre", out, 64'd300);
    flush = 1;
    cyc_n(1);
    flush = 0;
    check("flush_done_valid", 64'(out_valid), 64'd0);
    check("flush_done_out", out, 64'd0);
    // flush beats in_valid in IDLE
    in_valid = 1; flush = 1; in1 = 32'd1; in2 = 32'd1;
    cyc_n(1);
    in_valid = 0; flush = 0;
    check("flush_no_accept", 64'(busy), 64'd0);
    // random traffic with boundary-biased operands
    repeat (4000) begin
      logic [W-1:0] v [4];
      v[0] = '0; v[1] = 32'd1; v[2] = '1; v[3] = $urandom;
      in1       = v[$urandom_range(0, 3)];
      in2       = v[$urandom_range(0, 3)];
      in_valid  = $urandom_range(0, 1);
      out_ready = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 199) == 0;
      reset     = $urandom_range(0, 499) == 0;
      cyc_n(1);
    end
    reset = 0; flush = 0; in_valid = 0; out_ready = 0;
    cyc_n(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; the product is 2*WIDTH wide.
REQ-002 SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operands presented.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port in1  input  WIDTH  unsigned multiplicand.
REQ-007 SHALL have port in2  input  WIDTH  unsigned multiplier.
REQ-008 SHALL have port flush  input  1  synchronous abort of any operation in progress.
REQ-009 SHALL have port out_valid  output  1  product available.
REQ-010 SHALL have port out_ready  input  1  consumer takes product.
REQ-011 SHALL have port out  output  2*WIDTH  unsigned product in1*in2.
REQ-012 SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 SHALL assert in_ready only in IDLE; accept occurs on an edge where in_valid&&in_ready.
REQ-015 SHALL, on accept: latch in2 into the multiplier register; load accumulator with upper half 0 and lower half in1; clear the step counter; enter RUN.
REQ-016 SHALL perform exactly one shift-add step per RUN cycle: if accumulator bit 0 = 1, add the latched multiplier to the upper WIDTH bits with a (WIDTH+1)-bit sum; shift {carry, accumulator} right by one.
REQ-017 SHALL count steps 0..WIDTH-1; on the edge completing step WIDTH-1 it SHALL enter DONE.
REQ-018 SHALL produce out_valid exactly WIDTH (32) rising edges after the accept edge.
REQ-019 SHALL assert out_valid only in DONE, with out equal to the full accumulator; out SHALL be stable while out_valid=1 and out_ready=0.
REQ-020 SHALL, in DONE with out_ready=1, return to IDLE on that edge; no new operation is accepted on the same edge (in_ready=0 in DONE).
REQ-021 SHALL ignore in_valid, in1 and in2 outside IDLE; operand changes after accept SHALL NOT affect the result.
REQ-022 SHALL, on flush=1 in any state, return to IDLE on that edge, deassert out_valid and drop the result; flush with in_valid in IDLE SHALL NOT accept.
REQ-023 SHALL drive out to 0 whenever out_valid=0.
REQ-024 SHALL produce correct results for boundary operands: 0, 1, 2^WIDTH-1; no overflow is possible, since the product fits in 2*WIDTH bits.

Reset
REQ-025 SHALL, with reset=1 at a rising edge, enter IDLE and clear the accumulator, multiplier register and counter; reset has priority over flush and handshakes.
REQ-026 SHALL drive these output values during and after reset: in_ready=1, out_valid=0, busy=0, out=0.
REQ-027 SHALL, on reset mid-RUN or in DONE, discard the operation; no out_valid follows.

Structure
REQ-028 SHALL take WIDTH default, the state enum (IDLE/RUN/DONE) and the counter width constant ($clog2(WIDTH)+1) from shared package mult_pkg.
REQ-029 SHALL place the single shift-add step in one combinational sub-module, mult_step (inputs accumulator and multiplier; output next accumulator); the FSM, counter and registers stay in mult_sequencer.

Verification
REQ-030 SHALL cover basic multiply: in1=3, in2=5 accepted at edge T -> out_valid at T+32, out=64'd15, then IDLE with in_ready=1.
REQ-031 SHALL cover maximum operands: 0xFFFFFFFF * 0xFFFFFFFF -> out=64'hFFFFFFFE_00000001; also 0 * 0xFFFFFFFF -> 0.
REQ-032 SHALL cover backpressure: out_ready=0 for 5 cycles after out_valid with in_valid=1 and new operands -> out held, in_ready=0, no accept; on out_ready=1 -> IDLE next edge.
REQ-033 SHALL cover operand hold: change in1/in2 to 0 on the cycle after accepting 0x12345678 * 0x9ABCDEF0 -> out=64'h0B00EA4E_242D2080.
REQ-034 SHALL cover reset mid-operation: reset at step 10 -> IDLE, out_valid never asserts; the next op 7*6 -> 42 after 32 edges.
REQ-035 SHALL cover flush: flush in RUN and in DONE -> IDLE next edge, out_valid=0, out=0.
